// File: rtl/ngv_lcd_pkg.sv
// Shared types and helpers for the 8080-style LCD bus arbiter.
// Sequencer states, owner encoding and the round-robin tie-break rule.
package ngv_lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_ON,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_CS_OFF
    } lcd_state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int PHASE_W = 8;
    localparam int TMO_W   = 16;

    // A tie goes to whoever did not own the previous burst.
    function automatic logic rr_pick(input logic a_req, input logic b_req,
                                     input logic last_owner);
        if (a_req && b_req) begin
            return ~last_owner;
        end
        return b_req ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/lcd_bus_arb_if.sv
// Requester beat handshake plus LCD pin bundle for lcd_bus_arb.
// Latency/backpressure: none here; req is held until the one-cycle ack.
interface lcd_bus_arb_if #(
    parameter int DW = 24
);
    logic          a_req;
    logic          a_rs;
    logic [DW-1:0] a_data;
    logic          a_last;
    logic          a_ack;

    logic          b_req;
    logic          b_rs;
    logic [DW-1:0] b_data;
    logic          b_last;
    logic          b_ack;

    logic          lcd_cs;
    logic          lcd_rs;
    logic          lcd_wr;
    logic          lcd_rd;
    logic [DW-1:0] lcd_data;

    logic          busy;
    logic          owner;

    // Arbiter side.
    modport slave (
        input  a_req, a_rs, a_data, a_last,
        input  b_req, b_rs, b_data, b_last,
        output a_ack, b_ack,
        output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data,
        output busy, owner
    );

    // Requester / pin observer side.
    modport master (
        output a_req, a_rs, a_data, a_last,
        output b_req, b_rs, b_data, b_last,
        input  a_ack, b_ack,
        input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data,
        input  busy, owner
    );

endinterface

// File: rtl/lcd_beat_timer.sv
// Load/count-down phase counter shared by the SETUP, PULSE and HOLD phases.
// Latency: done is high once the loaded value has counted to zero; no backpressure.
module lcd_beat_timer
    import ngv_lcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               done
);

    logic [PHASE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_arb.sv
// Two-requester write sequencer/arbiter for the 8080 LCD bus, atomic bursts, round-robin.
// Latency: req in IDLE -> ack/data 2 cycles later; requesters hold req until ack.
module lcd_bus_arb
    import ngv_lcd_pkg::*;
#(
    parameter int DW      = 24,
    parameter int SETUP   = 2,
    parameter int PULSE   = 3,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    lcd_bus_arb_if.slave  bus
);

    // The timer expires on its zero count, so each phase loads length-1.
    localparam logic [PHASE_W-1:0] SETUP_LD = PHASE_W'(SETUP - 1);
    localparam logic [PHASE_W-1:0] PULSE_LD = PHASE_W'(PULSE - 1);
    localparam logic [PHASE_W-1:0] HOLD_LD  = PHASE_W'(HOLD - 1);
    localparam logic [TMO_W-1:0]   TMO_LIM  = TMO_W'(TIMEOUT);

    lcd_state_e         state_q, state_nxt;
    logic               owner_q, owner_nxt;
    logic               last_owner_q, last_owner_nxt;
    logic [TMO_W-1:0]   tmo_q, tmo_nxt;
    logic               accept;
    logic               lat_last_q;

    logic               tmr_load;
    logic [PHASE_W-1:0] tmr_val;
    logic               tmr_done;

    logic               cs_q, wr_q, rs_q, busy_q;
    logic [DW-1:0]      data_q;
    logic               a_ack_q, b_ack_q;

    logic               cur_req, cur_rs, cur_last;
    logic [DW-1:0]      cur_data;

    assign cur_req  = (owner_q == OWN_B) ? bus.b_req  : bus.a_req;
    assign cur_rs   = (owner_q == OWN_B) ? bus.b_rs   : bus.a_rs;
    assign cur_last = (owner_q == OWN_B) ? bus.b_last : bus.a_last;
    assign cur_data = (owner_q == OWN_B) ? bus.b_data : bus.a_data;

    always_comb begin
        state_nxt      = state_q;
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner_q;
        tmo_nxt        = tmo_q;
        accept         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    owner_nxt = rr_pick(bus.a_req, bus.b_req, last_owner_q);
                    state_nxt = ST_CS_ON;
                end
            end
            ST_CS_ON: begin
                accept    = 1'b1;
                state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (tmr_done) state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                if (tmr_done) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    if (lat_last_q) begin
                        state_nxt = ST_CS_OFF;
                    end else if (cur_req) begin
                        accept    = 1'b1;
                        state_nxt = ST_SETUP;
                    end else begin
                        tmo_nxt   = '0;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Only the owner can resume; the other side waits for IDLE.
                if (cur_req) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end else if (tmo_q == TMO_LIM) begin
                    state_nxt = ST_CS_OFF;
                end else begin
                    tmo_nxt = tmo_q + 1'b1;
                end
            end
            ST_CS_OFF: begin
                last_owner_nxt = owner_q;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every state change reloads the phase counter with the new phase length.
    always_comb begin
        tmr_val = '0;
        case (state_nxt)
            ST_SETUP: tmr_val = SETUP_LD;
            ST_PULSE: tmr_val = PULSE_LD;
            ST_HOLD:  tmr_val = HOLD_LD;
            default:  tmr_val = '0;
        endcase
    end

    assign tmr_load = (state_nxt != state_q);

    lcd_beat_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Pin values are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_A;
            last_owner_q <= OWN_B;
            tmo_q        <= '0;
            lat_last_q   <= 1'b0;
            cs_q         <= 1'b1;
            wr_q         <= 1'b1;
            rs_q         <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            owner_q      <= owner_nxt;
            last_owner_q <= last_owner_nxt;
            tmo_q        <= tmo_nxt;
            cs_q         <= !(state_nxt inside {ST_CS_ON, ST_SETUP, ST_PULSE,
                                                ST_HOLD, ST_WAIT});
            wr_q         <= (state_nxt != ST_PULSE);
            busy_q       <= (state_nxt != ST_IDLE);
            a_ack_q      <= accept && (owner_q == OWN_A);
            b_ack_q      <= accept && (owner_q == OWN_B);
            if (accept) begin
                rs_q       <= cur_rs;
                data_q     <= cur_data;
                lat_last_q <= cur_last;
            end
        end
    end

    assign bus.lcd_cs   = cs_q;
    assign bus.lcd_wr   = wr_q;
    assign bus.lcd_rd   = 1'b1;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_data = data_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.busy     = busy_q;
    assign bus.owner    = owner_q;

endmodule

// File: tb/tb_lcd_bus_arb.sv
// Directed bench for lcd_bus_arb: transaction-level model compared every cycle,
// plus literal timing expectations for the single-beat, tie, burst, atomicity, timeout and reset cases.
module tb_lcd_bus_arb;
    import ngv_lcd_pkg::*;

    localparam int DW      = 24;
    localparam int SETUP   = 2;
    localparam int PULSE   = 3;
    localparam int HOLD    = 2;
    localparam int TIMEOUT = 16;
    localparam int BP      = SETUP + PULSE + HOLD;
    localparam int LOGN    = 4096;

    localparam int F_CS = 0, F_WR = 1, F_BUSY = 2, F_AACK = 3, F_BACK = 4;
    localparam int P_IDLE = 0, P_SEL = 1, P_BEAT = 2, P_GAP = 3, P_REL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lcd_bus_arb_if #(.DW(DW)) bus ();

    lcd_bus_arb #(
        .DW(DW), .SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          req;
        logic          rs;
        logic          last;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        int            ph;
        logic          own;
        logic          last_own;
        int            off;
        int            gap;
        logic          rs;
        logic [DW-1:0] data;
        logic          last;
        logic          a_ack;
        logic          b_ack;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.ph = P_IDLE; r.own = 1'b0; r.last_own = 1'b1; r.off = 0; r.gap = 0;
        r.rs = 1'b0; r.data = '0; r.last = 1'b0; r.a_ack = 1'b0; r.b_ack = 1'b0;
        return r;
    endfunction

    function automatic mdl_t take_beat(input mdl_t s, input req_t r);
        mdl_t n = s;
        n.ph = P_BEAT; n.off = 0;
        n.rs = r.rs; n.data = r.data; n.last = r.last;
        if (s.own) n.b_ack = 1'b1;
        else       n.a_ack = 1'b1;
        return n;
    endfunction

    function automatic mdl_t model_next(input mdl_t s, input req_t a, input req_t b);
        mdl_t n = s;
        req_t cur = s.own ? b : a;
        n.a_ack = 1'b0;
        n.b_ack = 1'b0;
        case (s.ph)
            P_IDLE: if (a.req || b.req) begin
                n.own = (a.req && b.req) ? !s.last_own : b.req;
                n.ph  = P_SEL;
            end
            P_SEL: n = take_beat(n, cur);
            P_BEAT: begin
                if (s.off == BP - 1) begin
                    if (s.last)         n.ph = P_REL;
                    else if (cur.req)   n = take_beat(n, cur);
                    else begin n.ph = P_GAP; n.gap = 0; end
                end else begin
                    n.off = s.off + 1;
                end
            end
            P_GAP: begin
                if (cur.req)                n = take_beat(n, cur);
                else if (s.gap == TIMEOUT)  n.ph = P_REL;
                else                        n.gap = s.gap + 1;
            end
            default: begin
                n.last_own = s.own;
                n.ph = P_IDLE;
            end
        endcase
        return n;
    endfunction

    mdl_t m;
    req_t ra, rb;
    assign ra = '{req: bus.a_req, rs: bus.a_rs, last: bus.a_last, data: bus.a_data};
    assign rb = '{req: bus.b_req, rs: bus.b_rs, last: bus.b_last, data: bus.b_data};

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= mdl_reset();
        else      m <= model_next(m, ra, rb);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_cs",    32'(bus.lcd_cs),   32'(!(m.ph == P_SEL || m.ph == P_BEAT || m.ph == P_GAP)));
            chk("cmp_wr",    32'(bus.lcd_wr),   32'(!(m.ph == P_BEAT && m.off >= SETUP && m.off < SETUP + PULSE)));
            chk("cmp_rd",    32'(bus.lcd_rd),   32'h1);
            chk("cmp_rs",    32'(bus.lcd_rs),   32'(m.rs));
            chk("cmp_data",  32'(bus.lcd_data), 32'(m.data));
            chk("cmp_a_ack", 32'(bus.a_ack),    32'(m.a_ack));
            chk("cmp_b_ack", 32'(bus.b_ack),    32'(m.b_ack));
            chk("cmp_busy",  32'(bus.busy),     32'(m.ph != P_IDLE));
            chk("cmp_owner", 32'(bus.owner),    32'(m.own));
        end
    end

    // ---------------- per-cycle log for literal timing checks ----------------
    typedef struct packed {
        logic          cs, wr, busy, a_ack, b_ack, rs;
        logic [DW-1:0] data;
    } log_t;

    log_t lg [0:LOGN-1];

    always @(negedge clk) begin
        if (cyc < LOGN)
            lg[cyc] <= '{cs: bus.lcd_cs, wr: bus.lcd_wr, busy: bus.busy, a_ack: bus.a_ack,
                         b_ack: bus.b_ack, rs: bus.lcd_rs, data: bus.lcd_data};
    end

    function automatic logic fld(input int c, input int sel);
        case (sel)
            F_CS:    return lg[c].cs;
            F_WR:    return lg[c].wr;
            F_BUSY:  return lg[c].busy;
            F_AACK:  return lg[c].a_ack;
            default: return lg[c].b_ack;
        endcase
    endfunction

    function automatic int find(input int from, input int to, input int sel, input logic v);
        for (int c = from; c <= to; c++)
            if (c >= 0 && c < LOGN && c < cyc && fld(c, sel) == v) return c;
        return -1;
    endfunction

    function automatic int count(input int from, input int to, input int sel, input logic v);
        int n = 0;
        for (int c = from; c <= to; c++)
            if (c >= 0 && c < LOGN && c < cyc && fld(c, sel) == v) n++;
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic who, input int n, input logic [DW-1:0] d0,
                         input logic [DW-1:0] step, input logic rs, input logic last_final);
        logic [DW-1:0] d;
        int t;
        logic ack;
        d = d0;
        for (int k = 0; k < n; k++) begin
            if (who == OWN_B) begin
                bus.b_rs = rs; bus.b_data = d; bus.b_last = (k == n - 1) && last_final; bus.b_req = 1'b1;
            end else begin
                bus.a_rs = rs; bus.a_data = d; bus.a_last = (k == n - 1) && last_final; bus.a_req = 1'b1;
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
                ack = (who == OWN_B) ? bus.b_ack : bus.a_ack;
            end while (ack !== 1'b1 && t < 400);
            chk(who ? "b_ack_wait" : "a_ack_wait", 32'(ack), 32'h1);
            d = d + step;
        end
        if (who == OWN_B) bus.b_req = 1'b0;
        else              bus.a_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.busy !== 1'b0 && t < 400);
        chk("idle_wait", 32'(bus.busy), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic tie_pair(input string tag);
        int base, ta, tb;
        base = cyc;
        fork
            drive(OWN_A, 1, 24'hA1A1A1, 24'h0, 1'b0, 1'b1);
            drive(OWN_B, 1, 24'hB1B1B1, 24'h0, 1'b0, 1'b1);
        join
        wait_idle();
        ta = find(base, base + 60, F_AACK, 1'b1);
        tb = find(base, base + 60, F_BACK, 1'b1);
        chk({tag, "_a_ack_rel"}, 32'(ta - base), 32'd2);
        chk({tag, "_b_ack_rel"}, 32'(tb - base), 32'd12);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base, c0, c1, n;
        int ack [4];

        bus.a_req = 0; bus.a_rs = 0; bus.a_data = '0; bus.a_last = 0;
        bus.b_req = 0; bus.b_rs = 0; bus.b_data = '0; bus.b_last = 0;

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_cs",    32'(bus.lcd_cs),   32'h1);
        chk("rst_wr",    32'(bus.lcd_wr),   32'h1);
        chk("rst_rd",    32'(bus.lcd_rd),   32'h1);
        chk("rst_rs",    32'(bus.lcd_rs),   32'h0);
        chk("rst_data",  32'(bus.lcd_data), 32'h0);
        chk("rst_busy",  32'(bus.busy),     32'h0);
        chk("rst_owner", 32'(bus.owner),    32'h0);
        chk("rst_acks",  32'({bus.a_ack, bus.b_ack}), 32'h0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single beat
        base = cyc;
        drive(OWN_A, 1, 24'h00002C, 24'h0, 1'b1, 1'b1);
        wait_idle();
        c0 = find(base, base + 40, F_AACK, 1'b1);
        chk("single_ack_rel", 32'(c0 - base), 32'd2);
        chk("single_data", 32'(lg[c0].data), 32'h00002C);
        chk("single_rs", 32'(lg[c0].rs), 32'h1);
        c0 = find(base, base + 40, F_WR, 1'b0);
        c1 = find(c0, base + 40, F_WR, 1'b1);
        chk("single_wr_fall", 32'(c0 - base), 32'd4);
        chk("single_wr_last_low", 32'(c1 - 1 - base), 32'd6);
        c0 = find(base, base + 40, F_CS, 1'b0);
        c1 = find(c0, base + 40, F_CS, 1'b1);
        chk("single_cs_first_low", 32'(c0 - base), 32'd1);
        chk("single_cs_last_low", 32'(c1 - 1 - base), 32'd8);
        chk("single_busy_drop", 32'(find(base + 1, base + 40, F_BUSY, 1'b0) - base), 32'd10);

        // Ties after a fresh reset: A, then B; the next tie goes to A again
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk); #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        tie_pair("tie1");
        tie_pair("tie2");

        // Back-to-back burst from B
        base = cyc;
        drive(OWN_B, 3, 24'h111111, 24'h111111, 1'b0, 1'b1);
        wait_idle();
        ack[0] = find(base, base + 60, F_BACK, 1'b1);
        ack[1] = find(ack[0] + 1, base + 60, F_BACK, 1'b1);
        ack[2] = find(ack[1] + 1, base + 60, F_BACK, 1'b1);
        chk("burst_ack0_rel", 32'(ack[0] - base), 32'd2);
        chk("burst_ack_gap1", 32'(ack[1] - ack[0]), 32'd7);
        chk("burst_ack_gap2", 32'(ack[2] - ack[1]), 32'd7);
        chk("burst_data0", 32'(lg[ack[0]].data), 32'h111111);
        chk("burst_data1", 32'(lg[ack[1]].data), 32'h222222);
        chk("burst_data2", 32'(lg[ack[2]].data), 32'h333333);
        chk("burst_cs_low_cycles", 32'(count(base, base + 60, F_CS, 1'b0)), 32'd22);

        // Atomicity: B raises req three cycles into a 4-beat A burst
        base = cyc;
        fork
            drive(OWN_A, 4, 24'hA00001, 24'h000001, 1'b1, 1'b1);
            begin
                repeat (3) @(negedge clk);
                drive(OWN_B, 1, 24'hBBBBBB, 24'h0, 1'b0, 1'b1);
            end
        join
        wait_idle();
        c0 = base;
        for (int k = 0; k < 4; k++) begin
            ack[k] = find(c0, base + 80, F_AACK, 1'b1);
            c0 = ack[k] + 1;
            chk("atom_a_data", 32'(lg[ack[k]].data), 32'(24'hA00001 + 24'(k)));
        end
        chk("atom_a_ack0_rel", 32'(ack[0] - base), 32'd2);
        chk("atom_a_ack3_rel", 32'(ack[3] - base), 32'd23);
        c1 = find(base, base + 80, F_BACK, 1'b1);
        chk("atom_b_ack_rel", 32'(c1 - base), 32'd33);
        n = 0;
        for (int c = base; c < c1; c++) if (lg[c].data == 24'hBBBBBB) n++;
        chk("atom_no_b_data_early", 32'(n), 32'd0);

        // Timeout: A beat with last=0 then silence, B pending
        base = cyc;
        fork
            drive(OWN_A, 1, 24'hC0FFEE, 24'h0, 1'b0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                drive(OWN_B, 1, 24'h0B0B0B, 24'h0, 1'b1, 1'b1);
            end
        join
        wait_idle();
        chk("tmo_cs_rise_rel", 32'(find(base + 2, base + 80, F_CS, 1'b1) - base), 32'd26);
        chk("tmo_b_ack_rel", 32'(find(base, base + 80, F_BACK, 1'b1) - base), 32'd29);

        // Reset in the middle of PULSE
        bus.a_rs = 1'b1; bus.a_data = 24'h5A5A5A; bus.a_last = 1'b1; bus.a_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.lcd_wr !== 1'b0 && n < 50);
        chk("rst_reach_pulse", 32'(bus.lcd_wr), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("arst_wr",   32'(bus.lcd_wr),  32'h1);
        chk("arst_cs",   32'(bus.lcd_cs),  32'h1);
        chk("arst_busy", 32'(bus.busy),    32'h0);
        chk("arst_ack",  32'(bus.a_ack),   32'h0);
        bus.a_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'h0);
        tie_pair("tie_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_bus_arb.md
# lcd_bus_arb

Write-only sequencer and arbiter for the 8080-style parallel LCD bus. It shares `lcd_cs/rs/wr/rd/data` between two requesters: requester A (MCU command path fed from FMC) and requester B (internal fill/blit engine). It generates programmable setup/pulse/hold strobe timing and keeps bursts atomic. Fairness between bursts is round-robin. It sits between the requesters and the LCD pins in the `ngv_main` top level, clocked from the 168 MHz PLL output.

## Interface
- `DW`, 24: LCD data width.
- `SETUP`, 2: cycles from data/rs valid to `lcd_wr` fall (1..255).
- `PULSE`, 3: cycles `lcd_wr` held low (1..255).
- `HOLD`, 2: cycles data held after `lcd_wr` rise (1..255).
- `TIMEOUT`, 255: idle cycles inside a burst before forced release (1..65535).

- `clk`  in  1  system clock (168 MHz domain).
- `rst`  in  1  asynchronous reset, active-low.
- `a_req`, `b_req`  in  1  beat request; held high with rs/data/last stable until ack.
- `a_rs`, `b_rs`  in  1  register-select for the beat.
- `a_data`, `b_data`  in  DW  beat data.
- `a_last`, `b_last`  in  1  beat is final of burst.
- `a_ack`, `b_ack`  out  1  one-cycle pulse: beat accepted, inputs latched.
- `lcd_cs`, `lcd_rs`, `lcd_wr`, `lcd_rd`  out  1  LCD strobes (cs/wr/rd active-low).
- `lcd_data`  out  DW  LCD data.
- `busy`  out  1  state ≠ IDLE.
- `owner`  out  1  current/last grantee (0 = A, 1 = B).

## Operation
- States: IDLE, CS_ON, SETUP, PULSE, HOLD, WAIT, CS_OFF.
- IDLE: if any req, grant. On tie, grant the requester that is not `last_owner`. `last_owner` resets to B, so A wins the first tie. Update `owner`, go to CS_ON.
- CS_ON (1 cycle): `lcd_cs`=0. Go to SETUP with beat-accept.
- Beat-accept: latch owner's rs/data/last into `lcd_rs/lcd_data`. Pulse owner's ack in the first SETUP cycle.
- SETUP (SETUP cycles) → PULSE (`lcd_wr`=0, PULSE cycles) → HOLD (HOLD cycles).
- Last HOLD cycle:
  - latched last=1 → CS_OFF.
  - else owner req=1 → SETUP with beat-accept, giving back-to-back beats.
  - else → WAIT.
- WAIT: `lcd_cs` stays low, data/rs hold the previous beat.
  - owner req → SETUP with beat-accept.
  - TIMEOUT cycles without req → CS_OFF.
  - The other requester never preempts: bursts are atomic.
- CS_OFF (1 cycle): `lcd_cs`=1. Set `last_owner`=owner. Go to IDLE.
- The non-owner's req is ignored until IDLE and never acked early.
- `lcd_rd` is constant 1.
- Reset (async, any state): all outputs return to reset values immediately, the burst is abandoned, and no ack is produced.

## Timing
- Reset values: `lcd_cs`=1, `lcd_wr`=1, `lcd_rd`=1, `lcd_rs`=0, `lcd_data`=0, acks=0, `busy`=0, `owner`=0, `last_owner`=1.
- All outputs are registered; no combinational path from inputs to outputs.
- Beat period is SETUP+PULSE+HOLD cycles (default 7). Acks of back-to-back beats are exactly one beat period apart.
- Latency: req seen in IDLE at cycle 0 → CS_ON at 1 → ack and data valid at 2 → `lcd_wr` low cycles 4–6.
- Burst of N beats with no gaps: `lcd_cs` low for 1 + N·7 cycles (defaults).
- After ack, the requester may change inputs from the next cycle. req is re-sampled only in the last HOLD cycle or in WAIT.
- Phase counter is 8 bits and reloads on each state entry. Timeout counter is 16 bits and clears on entry to WAIT.

## Structure
- Package `ngv_lcd_pkg`: state enum, constants `OWN_A`=0 and `OWN_B`=1.
- Sub-module `lcd_beat_timer`: load/count-down phase counter with `done` flag, shared by SETUP/PULSE/HOLD.
- Top `lcd_bus_arb`: FSM, round-robin, latches, timeout.

## Test plan
- Single beat: A req, rs=1, data=0x00002C, last=1 → a_ack at cycle 2; `lcd_wr` low cycles 4–6; `lcd_cs` low cycles 1–8; `busy` drops at cycle 10.
- Tie: A and B req in the same cycle after reset → A granted first. After A's burst, B is granted. Next tie → A.
- Burst: B gives 3 beats, data 0x111111/0x222222/0x333333, req held continuously → b_ack every 7 cycles; `lcd_cs` low 22 cycles; data order preserved.
- Atomicity: B req raised during an A 4-beat burst → no b_ack until A's CS_OFF, and no B data between A beats.
- Timeout: A sends a beat with last=0, then drops req; TIMEOUT=16 → `lcd_cs` rises 17 cycles after WAIT entry; a pending B is granted next.
- Reset: `rst` low during PULSE → `lcd_wr`, `lcd_cs` high immediately. After release, IDLE, and A wins the next tie.
